// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control/address register chain.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 6;

    // Decode-stage control bundle carried into E.
    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
        logic MemWrite;
        logic PCSrc;
        logic Branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // Control bundle carried into M (branch already resolved in E).
    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
        logic MemWrite;
        logic PCSrc;
    } memCtrl_t;

    localparam int unsigned MEM_CTRL_W = $bits(memCtrl_t);

    // Control bundle carried into W (memory write already performed in M).
    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
        logic PCSrc;
    } wbCtrl_t;

    localparam int unsigned WB_CTRL_W = $bits(wbCtrl_t);

    // Suppress architectural side effects of an instruction whose condition failed.
    function automatic memCtrl_t gateCtrl(input memCtrl_t c, input logic condEx);
        memCtrl_t g;
        g.RegWrite = c.RegWrite & condEx;
        g.MemToReg = c.MemToReg;
        g.MemWrite = c.MemWrite & condEx;
        g.PCSrc    = c.PCSrc & condEx;
        return g;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: sync reset, clear (bubble) beats enable.
module pipe_stage_reg #(
    parameter int unsigned W = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Priority: reset, then clear to bubble, then load when enabled.
    always_ff @(posedge CLK) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// F/D, D/E, E/M and M/W control/address registers feeding the hazard unit.
module pipe_ctrl_regs #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 6
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [DATA_W-1:0] InstrF,
    input  logic [DATA_W-1:0] PCPlus4F,
    output logic [DATA_W-1:0] InstrD,
    output logic [DATA_W-1:0] PCPlus4D,
    input  logic              RegWriteD,
    input  logic              MemToRegD,
    input  logic              MemWriteD,
    input  logic              PCSrcD,
    input  logic              BranchD,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              CondExE,
    output logic [REG_AW-1:0] RA1E,
    output logic [REG_AW-1:0] RA2E,
    output logic [REG_AW-1:0] WA3E,
    output logic              RegWriteE,
    output logic              MemToRegE,
    output logic              MemWriteE,
    output logic              PCSrcE,
    output logic              BranchE,
    output logic              BranchTakenE,
    output logic              RegWriteM,
    output logic              MemToRegM,
    output logic              MemWriteM,
    output logic              PCSrcM,
    output logic [REG_AW-1:0] WA3M,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic              PCSrcW,
    output logic [REG_AW-1:0] WA3W,
    output logic              ValidE,
    output logic              ValidM,
    output logic              ValidW
);

    import pipe_pkg::*;

    localparam int unsigned FD_W = 2 * DATA_W + 1;
    localparam int unsigned DE_W = CTRL_W + 3 * REG_AW + 1;
    localparam int unsigned EM_W = MEM_CTRL_W + REG_AW + 1;
    localparam int unsigned MW_W = WB_CTRL_W + REG_AW + 1;
    localparam logic [DE_W-1:0] DE_BUBBLE = {CTRL_BUBBLE, (DE_W - CTRL_W)'(0)};

    logic              validD;
    ctrl_t             ctrlD;
    ctrl_t             ctrlE;
    memCtrl_t          ctrlEm;
    memCtrl_t          ctrlM;
    wbCtrl_t           ctrlW;
    logic [FD_W-1:0]   fdD;
    logic [FD_W-1:0]   fdQ;
    logic [DE_W-1:0]   deD;
    logic [DE_W-1:0]   deQ;
    logic [EM_W-1:0]   emD;
    logic [EM_W-1:0]   emQ;
    logic [MW_W-1:0]   mwD;
    logic [MW_W-1:0]   mwQ;

    // F/D: fetch payload, held on StallD, bubbled on FlushD.
    assign fdD = {InstrF, PCPlus4F, 1'b1};

    pipe_stage_reg #(.W(FD_W)) uFd (
        .CLK   (CLK),
        .reset (reset),
        .en    (!StallD),
        .clr   (FlushD),
        .d     (fdD),
        .q     (fdQ)
    );

    assign {InstrD, PCPlus4D, validD} = fdQ;

    // D/E: decoder controls and register addresses, bubbled on FlushE.
    assign ctrlD = '{RegWrite: RegWriteD, MemToReg: MemToRegD, MemWrite: MemWriteD,
                     PCSrc: PCSrcD, Branch: BranchD};
    assign deD   = {ctrlD, RA1D, RA2D, WA3D, validD};

    pipe_stage_reg #(.W(DE_W), .CLR_VAL(DE_BUBBLE)) uDe (
        .CLK   (CLK),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (deD),
        .q     (deQ)
    );

    assign {ctrlE, RA1E, RA2E, WA3E, ValidE} = deQ;
    assign RegWriteE    = ctrlE.RegWrite;
    assign MemToRegE    = ctrlE.MemToReg;
    assign MemWriteE    = ctrlE.MemWrite;
    assign PCSrcE       = ctrlE.PCSrc;
    assign BranchE      = ctrlE.Branch;
    assign BranchTakenE = ctrlE.Branch & CondExE;

    // E/M: side-effect controls gated by the condition check.
    assign ctrlEm = '{RegWrite: ctrlE.RegWrite, MemToReg: ctrlE.MemToReg,
                      MemWrite: ctrlE.MemWrite, PCSrc: ctrlE.PCSrc};
    assign emD    = {gateCtrl(ctrlEm, CondExE), WA3E, ValidE};

    pipe_stage_reg #(.W(EM_W)) uEm (
        .CLK   (CLK),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (emD),
        .q     (emQ)
    );

    assign {ctrlM, WA3M, ValidM} = emQ;
    assign RegWriteM = ctrlM.RegWrite;
    assign MemToRegM = ctrlM.MemToReg;
    assign MemWriteM = ctrlM.MemWrite;
    assign PCSrcM    = ctrlM.PCSrc;

    // M/W: writeback controls straight through.
    assign mwD = {ctrlM.RegWrite, ctrlM.MemToReg, ctrlM.PCSrc, WA3M, ValidM};

    pipe_stage_reg #(.W(MW_W)) uMw (
        .CLK   (CLK),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (mwD),
        .q     (mwQ)
    );

    assign {ctrlW, WA3W, ValidW} = mwQ;
    assign RegWriteW = ctrlW.RegWrite;
    assign MemToRegW = ctrlW.MemToReg;
    assign PCSrcW    = ctrlW.PCSrc;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Self-checking bench for pipe_ctrl_regs: directed scenarios plus random traffic.
module tb_pipe_ctrl_regs;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 6;

    logic              CLK = 1'b0;
    logic              reset, StallD, FlushD, FlushE, CondExE;
    logic [DATA_W-1:0] InstrF, PCPlus4F, InstrD, PCPlus4D;
    logic              RegWriteD, MemToRegD, MemWriteD, PCSrcD, BranchD;
    logic [REG_AW-1:0] RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic              RegWriteE, MemToRegE, MemWriteE, PCSrcE, BranchE, BranchTakenE;
    logic              RegWriteM, MemToRegM, MemWriteM, PCSrcM;
    logic              RegWriteW, MemToRegW, PCSrcW;
    logic              ValidE, ValidM, ValidW;

    int errors = 0;
    int checks = 0;

    // One in-flight instruction as seen at a stage boundary.
    typedef struct {
        logic            rw, mtr, mw, pcs, br;
        logic [REG_AW-1:0] ra1, ra2, wa3;
        logic            v;
    } stg_t;

    stg_t        mE, mM, mW;
    logic [31:0] mInstrD, mPcD;
    logic        mValidD;

    pipe_ctrl_regs #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .CLK(CLK), .reset(reset), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .InstrF(InstrF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
        .PCSrcD(PCSrcD), .BranchD(BranchD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .CondExE(CondExE), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
        .PCSrcE(PCSrcE), .BranchE(BranchE), .BranchTakenE(BranchTakenE),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
        .PCSrcM(PCSrcM), .WA3M(WA3M), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .PCSrcW(PCSrcW), .WA3W(WA3W), .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Single comparison point for every check.
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stg_t emptyStage();
        stg_t s;
        s = '{rw: 1'b0, mtr: 1'b0, mw: 1'b0, pcs: 1'b0, br: 1'b0,
              ra1: '0, ra2: '0, wa3: '0, v: 1'b0};
        return s;
    endfunction

    task automatic modelReset();
        mE = emptyStage(); mM = emptyStage(); mW = emptyStage();
        mInstrD = '0; mPcD = '0; mValidD = 1'b0;
    endtask

    // Compare every registered output against the reference pipeline.
    task automatic checkAll();
        checkVal("InstrD",    InstrD,          mInstrD);
        checkVal("PCPlus4D",  PCPlus4D,        mPcD);
        checkVal("RA1E",      32'(RA1E),       32'(mE.ra1));
        checkVal("RA2E",      32'(RA2E),       32'(mE.ra2));
        checkVal("WA3E",      32'(WA3E),       32'(mE.wa3));
        checkVal("RegWriteE", 32'(RegWriteE),  32'(mE.rw));
        checkVal("MemToRegE", 32'(MemToRegE),  32'(mE.mtr));
        checkVal("MemWriteE", 32'(MemWriteE),  32'(mE.mw));
        checkVal("PCSrcE",    32'(PCSrcE),     32'(mE.pcs));
        checkVal("BranchE",   32'(BranchE),    32'(mE.br));
        checkVal("ValidE",    32'(ValidE),     32'(mE.v));
        checkVal("RegWriteM", 32'(RegWriteM),  32'(mM.rw));
        checkVal("MemToRegM", 32'(MemToRegM),  32'(mM.mtr));
        checkVal("MemWriteM", 32'(MemWriteM),  32'(mM.mw));
        checkVal("PCSrcM",    32'(PCSrcM),     32'(mM.pcs));
        checkVal("WA3M",      32'(WA3M),       32'(mM.wa3));
        checkVal("ValidM",    32'(ValidM),     32'(mM.v));
        checkVal("RegWriteW", 32'(RegWriteW),  32'(mW.rw));
        checkVal("MemToRegW", 32'(MemToRegW),  32'(mW.mtr));
        checkVal("PCSrcW",    32'(PCSrcW),     32'(mW.pcs));
        checkVal("WA3W",      32'(WA3W),       32'(mW.wa3));
        checkVal("ValidW",    32'(ValidW),     32'(mW.v));
    endtask

    // Advance one cycle with the currently driven inputs, then check everything.
    task automatic step();
        stg_t        nE, nM, nW;
        logic [31:0] nI, nP;
        logic        nV;
        #1;
        checkVal("BranchTakenE", 32'(BranchTakenE), 32'(mE.br & CondExE));
        nW = mM;
        nW.mw = 1'b0;
        nM = mE;
        nM.rw  = mE.rw & CondExE;
        nM.mw  = mE.mw & CondExE;
        nM.pcs = mE.pcs & CondExE;
        nM.br  = 1'b0;
        if (FlushE) nE = emptyStage();
        else nE = '{rw: RegWriteD, mtr: MemToRegD, mw: MemWriteD, pcs: PCSrcD,
                    br: BranchD, ra1: RA1D, ra2: RA2D, wa3: WA3D, v: mValidD};
        if (FlushD) begin
            nI = '0; nP = '0; nV = 1'b0;
        end else if (StallD) begin
            nI = mInstrD; nP = mPcD; nV = mValidD;
        end else begin
            nI = InstrF; nP = PCPlus4F; nV = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (reset) modelReset();
        else begin
            mE = nE; mM = nM; mW = nW; mInstrD = nI; mPcD = nP; mValidD = nV;
        end
        checkAll();
    endtask

    task automatic idleInputs();
        reset = 0; StallD = 0; FlushD = 0; FlushE = 0; CondExE = 1;
        RegWriteD = 0; MemToRegD = 0; MemWriteD = 0; PCSrcD = 0; BranchD = 0;
        RA1D = '0; RA2D = '0; WA3D = '0;
        InstrF = $urandom; PCPlus4F = $urandom;
    endtask

    task automatic randomInputs();
        InstrF = $urandom; PCPlus4F = $urandom;
        RegWriteD = 1'($urandom); MemToRegD = 1'($urandom); MemWriteD = 1'($urandom);
        PCSrcD = 1'($urandom); BranchD = 1'($urandom); CondExE = 1'($urandom);
        RA1D = REG_AW'($urandom); RA2D = REG_AW'($urandom); WA3D = REG_AW'($urandom);
    endtask

    logic [31:0] heldInstr;

    initial begin
        modelReset();
        idleInputs();

        // Reset held for two cycles under random inputs.
        reset = 1; StallD = 1'($urandom); FlushD = 1'($urandom); FlushE = 1'($urandom);
        randomInputs();
        step();
        randomInputs();
        step();
        checkVal("rst_ValidW", 32'(ValidW), 32'd0);
        checkVal("rst_InstrD", InstrD, 32'd0);
        idleInputs();
        CondExE = 0;
        #1;
        checkVal("rst_BranchTakenE", 32'(BranchTakenE), 32'd0);

        // Propagation of a register write through E, M and W.
        idleInputs();
        RegWriteD = 1; WA3D = 6'd5; RA1D = 6'd1; RA2D = 6'd2;
        step();
        checkVal("prop_RA1E", 32'(RA1E), 32'd1);
        checkVal("prop_RA2E", 32'(RA2E), 32'd2);
        checkVal("prop_WA3E", 32'(WA3E), 32'd5);
        idleInputs();
        step();
        checkVal("prop_RegWriteM", 32'(RegWriteM), 32'd1);
        checkVal("prop_WA3M", 32'(WA3M), 32'd5);
        step();
        checkVal("prop_RegWriteW", 32'(RegWriteW), 32'd1);
        checkVal("prop_WA3W", 32'(WA3W), 32'd5);

        // Load-use: stall D and bubble E on the same edge.
        idleInputs();
        InstrF = 32'h0000_1234;
        step();
        heldInstr = 32'h0000_1234;
        MemToRegD = 1; WA3D = 6'd3; StallD = 1; FlushE = 1; InstrF = 32'hA;
        step();
        checkVal("lu_InstrD_held", InstrD, heldInstr);
        checkVal("lu_ValidE", 32'(ValidE), 32'd0);
        checkVal("lu_MemToRegE", 32'(MemToRegE), 32'd0);
        StallD = 0; FlushE = 0;
        step();
        checkVal("lu_MemToRegE_replay", 32'(MemToRegE), 32'd1);
        checkVal("lu_WA3E_replay", 32'(WA3E), 32'd3);
        checkVal("lu_ValidE_replay", 32'(ValidE), 32'd1);
        checkVal("lu_InstrD_next", InstrD, 32'hA);

        // Branch taken, then flush of D and E.
        idleInputs();
        BranchD = 1; RegWriteD = 1;
        step();
        idleInputs();
        RegWriteD = 1; CondExE = 1; FlushD = 1; FlushE = 1;
        #1;
        checkVal("br_BranchTakenE", 32'(BranchTakenE), 32'd1);
        step();
        checkVal("br_InstrD", InstrD, 32'd0);
        checkVal("br_ValidE", 32'(ValidE), 32'd0);
        checkVal("br_RegWriteE", 32'(RegWriteE), 32'd0);

        // Condition failure squashes side effects but keeps the slot valid.
        idleInputs();
        step();
        RegWriteD = 1; MemWriteD = 1; PCSrcD = 1; WA3D = 6'd7;
        step();
        idleInputs();
        CondExE = 0;
        step();
        checkVal("cf_RegWriteM", 32'(RegWriteM), 32'd0);
        checkVal("cf_MemWriteM", 32'(MemWriteM), 32'd0);
        checkVal("cf_PCSrcM", 32'(PCSrcM), 32'd0);
        checkVal("cf_ValidM", 32'(ValidM), 32'd1);
        checkVal("cf_WA3M", 32'(WA3M), 32'd7);

        // Mid-flight reset with writes in E, M and W.
        for (int i = 0; i < 3; i++) begin
            idleInputs();
            RegWriteD = 1; WA3D = REG_AW'(10 + i);
            step();
        end
        checkVal("mr_pre_RegWriteW", 32'(RegWriteW), 32'd1);
        idleInputs();
        reset = 1; RegWriteD = 1;
        step();
        checkVal("mr_RegWrite", 32'({RegWriteE, RegWriteM, RegWriteW}), 32'd0);
        checkVal("mr_Valid", 32'({ValidE, ValidM, ValidW}), 32'd0);

        // Random traffic; a bubble in D decodes to no controls.
        idleInputs();
        for (int n = 0; n < 400; n++) begin
            randomInputs();
            reset  = ($urandom_range(0, 39) == 0);
            StallD = ($urandom_range(0, 3) == 0);
            FlushD = ($urandom_range(0, 5) == 0);
            FlushE = ($urandom_range(0, 4) == 0);
            if (!mValidD) begin
                RegWriteD = 0; MemToRegD = 0; MemWriteD = 0; PCSrcD = 0; BranchD = 0;
            end
            step();
            if (!ValidM) checkVal("bub_M", 32'({RegWriteM, MemWriteM, PCSrcM}), 32'd0);
            if (!ValidW) checkVal("bub_W", 32'({RegWriteW, PCSrcW}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
Control/address pipeline register chain for the 5-stage pipelined CPU, directly upstream of the hazard unit.
- Carries decode-stage control bits and register addresses through the D/E, E/M and M/W boundaries.
- Produces RA1E, RA2E, WA3E/M/W, RegWriteM/W, MemToRegE, PCSrcE/M/W and BranchTakenE for the hazard unit.
- Consumes the hazard unit's StallD, FlushD and FlushE.
- Also holds the F/D instruction register.

Parameters:
- DATA_W, 32, instruction/PC width.
- REG_AW, 6, register address width (64 architectural registers).

Ports:
- CLK in 1: single clock, rising edge.
- reset in 1: synchronous, active-high.
- StallD in 1: hold F/D register (from hazard unit).
- FlushD in 1: clear F/D register to bubble (from hazard unit).
- FlushE in 1: clear D/E register to bubble (from hazard unit).
- InstrF in DATA_W: fetched instruction.
- PCPlus4F in DATA_W: fetch PC+4.
- InstrD out DATA_W: decode-stage instruction.
- PCPlus4D out DATA_W: decode-stage PC+4.
- RegWriteD, MemToRegD, MemWriteD, PCSrcD, BranchD in 1 each: decoder control bits.
- RA1D, RA2D, WA3D in REG_AW: decode read/write addresses.
- CondExE in 1: condition check passed for the instruction in E.
- RA1E, RA2E, WA3E out REG_AW: execute-stage addresses.
- RegWriteE, MemToRegE, MemWriteE, PCSrcE, BranchE out 1: raw E controls.
- BranchTakenE out 1: BranchE & CondExE (combinational).
- RegWriteM, MemToRegM, MemWriteM, PCSrcM out 1: gated M controls.
- WA3M out REG_AW.
- RegWriteW, MemToRegW, PCSrcW out 1.
- WA3W out REG_AW.
- ValidE, ValidM, ValidW out 1: stage holds a non-bubble instruction.

Behaviour:
- All registers update on rising CLK only.
- Reset: every registered output is 0, including InstrD=0, PCPlus4D=0, addresses=0 and Valid*=0.
- F/D register, priority reset > FlushD > StallD > load:
  - FlushD: InstrD=0, PCPlus4D=0, valid_d=0.
  - StallD (no flush): hold all values.
  - Otherwise: capture InstrF and PCPlus4F, valid_d=1.
- D/E register, priority reset > FlushE > load. There is no stall on E.
  - FlushE inserts a bubble: all E control bits 0, RA1E/RA2E/WA3E = 0, ValidE=0.
  - Otherwise: capture the *D inputs, ValidE=valid_d.
- E/M register, always loads, no stall or flush:
  - RegWriteM = RegWriteE & CondExE
  - MemWriteM = MemWriteE & CondExE
  - PCSrcM = PCSrcE & CondExE
  - MemToRegM = MemToRegE
  - WA3M = WA3E
  - ValidM = ValidE
- M/W register, always loads: RegWriteW, MemToRegW, PCSrcW, WA3W and ValidW copy their M-stage values.
- Latency: a D-stage control bit reaches E after 1 cycle, M after 2 and W after 3, absent flush.
- Simultaneous StallD & FlushE (load-use): F/D holds and E receives a bubble in the same edge. The stalled instruction re-enters E on the next non-stalled edge.
- Simultaneous StallD & FlushD: flush wins, and F/D becomes a bubble.
- FlushE with CondExE=0 on the same edge: both take effect independently. E becomes a bubble, and M receives gated (zero) write controls.
- A bubble never asserts RegWrite, MemWrite or PCSrc in any later stage.
- reset mid-operation: all stages are bubbles on the next edge. No in-flight write survives, and outputs return to 0 within 1 cycle.
- Addresses are passed unmodified. No arithmetic and no width conversion.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_AW.
  - typedef ctrl_t: struct packed {RegWrite, MemToReg, MemWrite, PCSrc, Branch}.
  - Constant CTRL_BUBBLE = '0.
- One natural sub-module, pipe_stage_reg: a parameterised-width register with en and clr inputs, where clr has priority over en.
  - Instantiated 4 times: F/D, D/E, E/M, M/W.
  - Enables and clears are tied per the rules above.

Test Plan:
- Reset: assert reset 2 cycles with random inputs, then check all outputs are 0, all Valid* are 0 and BranchTakenE=0.
- Propagation: RegWriteD=1, WA3D=6'd5, RA1D=6'd1, RA2D=6'd2, CondExE=1, no stall/flush.
  - Edge 1: RA1E=1, RA2E=2, WA3E=5.
  - Edge 2: RegWriteM=1, WA3M=5.
  - Edge 3: RegWriteW=1, WA3W=5.
- Load-use: MemToRegD=1, WA3D=3, then assert StallD=1 & FlushE=1 for one cycle with InstrF=32'hA.
  - InstrD holds its prior value.
  - ValidE=0 and MemToRegE=0 in the bubble cycle.
  - The held instruction reaches E on the following edge.
- Branch taken: BranchE=1 with CondExE=1 gives BranchTakenE=1 the same cycle. FlushD=1 & FlushE=1 then give InstrD=0, ValidE=0 and RegWriteE=0 after the edge.
- Condition fail: RegWriteE=1, MemWriteE=1, PCSrcE=1, CondExE=0 gives RegWriteM=0, MemWriteM=0 and PCSrcM=0 after the edge, while ValidM=1 and WA3M is still propagated.
- Mid-flight reset: three valid writes in E/M/W, then reset for 1 cycle. All RegWrite* and Valid* read 0 on the next edge.
